// File: rtl/cost_pair_counter.sv
// Satisfied-constraint pair counter (u = proposed, v = current) with a valid/ack
// handshake. Define COST_TIMEOUT_EN to add the ACCUM watchdog and out_timeout.
module cost_pair_counter #(
  parameter int COUNT_WIDTH    = 8,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                   in_clock,
  input  logic                   in_reset,
  input  logic                   in_start,
  input  logic                   in_constraint_valid,
  input  logic                   in_sat_current,
  input  logic                   in_sat_proposed,
  input  logic                   in_last,
  input  logic                   in_ack,
  output logic                   out_ready,
  output logic [COUNT_WIDTH-1:0] out_u,
  output logic [COUNT_WIDTH-1:0] out_v,
  output logic                   out_valid,
  output logic                   out_busy,
`ifdef COST_TIMEOUT_EN
  output logic                   out_timeout,
`endif
  output logic                   out_overflow
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

  if (TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] u_q, u_d, v_q, v_d;
  logic                   ovf_q, ovf_d;
  logic                   beat, start_acc, last_beat;

  assign start_acc = (state_q == IDLE) && in_start;
  assign beat      = (state_q == ACCUM) && in_constraint_valid;
  assign last_beat = beat && in_last;

`ifdef COST_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            to_q, to_d;
  logic            wd_expire;

  // A last beat landing on the expiry cycle wins over the watchdog.
  assign wd_expire = (state_q == ACCUM) && (wd_q == WD_LAST) && !last_beat;
`endif

  // State and datapath registers
  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      state_q <= IDLE;
      u_q     <= '0;
      v_q     <= '0;
      ovf_q   <= 1'b0;
`ifdef COST_TIMEOUT_EN
      wd_q    <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      u_q     <= u_d;
      v_q     <= v_d;
      ovf_q   <= ovf_d;
`ifdef COST_TIMEOUT_EN
      wd_q    <= wd_d;
      to_q    <= to_d;
`endif
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (in_start) state_d = ACCUM;
      ACCUM: begin
        if (last_beat) state_d = DONE;
`ifdef COST_TIMEOUT_EN
        else if (wd_expire) state_d = DONE;
`endif
      end
      DONE:  if (in_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Saturating counts; DONE leaves everything untouched so the pair holds
  always_comb begin
    u_d   = u_q;
    v_d   = v_q;
    ovf_d = ovf_q;
    if (start_acc) begin
      u_d   = '0;
      v_d   = '0;
      ovf_d = 1'b0;
    end else if (beat) begin
      if (in_sat_proposed) begin
        if (u_q == CNT_MAX) ovf_d = 1'b1;
        else                u_d   = u_q + 1'b1;
      end
      if (in_sat_current) begin
        if (v_q == CNT_MAX) ovf_d = 1'b1;
        else                v_d   = v_q + 1'b1;
      end
    end
`ifdef COST_TIMEOUT_EN
    wd_d = wd_q;
    to_d = to_q;
    if (start_acc) begin
      wd_d = '0;
      to_d = 1'b0;
    end else if (wd_expire) begin
      u_d  = '0;
      v_d  = '0;
      to_d = 1'b1;
    end else if (state_q == ACCUM) begin
      wd_d = wd_q + 1'b1;
    end
`endif
  end

  // Outputs
  always_comb begin
    out_ready    = (state_q == ACCUM);
    out_valid    = (state_q == DONE);
    out_busy     = (state_q != IDLE);
    out_u        = u_q;
    out_v        = v_q;
    out_overflow = ovf_q;
`ifdef COST_TIMEOUT_EN
    out_timeout  = to_q;
`endif
  end

endmodule
